// File: rtl/axi4_mem_tester_if.sv
// AXI4 master-side bundle for the memory tester: five channels, 64-bit data, 4-bit ids.
interface axi4_mem_tester_if;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        output bready,
        input  bvalid, bid, bresp,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        output rready,
        input  rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        input  bready,
        output bvalid, bid, bresp,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        input  rready,
        output rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_mem_tester.sv
// AXI4 memory tester: writes NUM_BURSTS INCR bursts of address-derived data, reads them back
// and counts failing beats/responses. Every output is driven straight from a flop.
module axi4_mem_tester #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] NUM_BURSTS = 16'd1024,
    parameter logic [7:0]  BURST_LEN  = 8'd15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [31:0]       first_err_addr,
    axi4_mem_tester_if.master io_axi4
);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
    } state_e;

    localparam logic [31:0] BurstBytes = ({24'd0, BURST_LEN} + 32'd1) << 3;

    state_e      state_q, state_d;
    logic [15:0] burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] baddr_q, baddr_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] first_err_q, first_err_d;

    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        wlast_q, wlast_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        fixed_en_q;

    logic        err_evt, end_burst, last_beat, last_burst;
    logic [31:0] err_addr, beat_addr, nxt_addr;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        baddr_d     = baddr_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_evt     = 1'b0;
        err_addr    = baddr_q;
        end_burst   = 1'b0;
        beat_addr   = baddr_q + {21'd0, beat_q, 3'd0};
        last_beat   = (beat_q == BURST_LEN);
        last_burst  = (burst_q == NUM_BURSTS - 16'd1);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWrAddr;
                    burst_d     = '0;
                    beat_d      = '0;
                    baddr_d     = BASE_ADDR;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
            end
            StWrAddr: begin
                if (awvalid_q && io_axi4.awready) begin
                    state_d = StWrData;
                    beat_d  = '0;
                end
            end
            StWrData: begin
                if (wvalid_q && io_axi4.wready) begin
                    if (last_beat) state_d = StWrResp;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            StWrResp: begin
                if (bready_q && io_axi4.bvalid) begin
                    err_evt   = (io_axi4.bresp != 2'b00);
                    end_burst = 1'b1;
                end
            end
            StRdAddr: begin
                if (arvalid_q && io_axi4.arready) begin
                    state_d = StRdData;
                    beat_d  = '0;
                end
            end
            StRdData: begin
                if (rready_q && io_axi4.rvalid) begin
                    err_evt  = (io_axi4.rdata != {beat_addr, ~beat_addr}) ||
                               (io_axi4.rresp != 2'b00) || (io_axi4.rlast != last_beat);
                    err_addr = beat_addr;
                    // An early rlast truncates the burst; the truncation itself is the error.
                    if (io_axi4.rlast || last_beat) end_burst = 1'b1;
                    else                            beat_d    = beat_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (end_burst) begin
            beat_d = '0;
            if (last_burst) begin
                burst_d = '0;
                baddr_d = BASE_ADDR;
                state_d = (state_q == StWrResp) ? StRdAddr : StDone;
            end else begin
                burst_d = burst_q + 16'd1;
                baddr_d = baddr_q + BurstBytes;
                state_d = (state_q == StWrResp) ? StWrAddr : StRdAddr;
            end
        end

        if (err_evt) begin
            if (err_cnt_q == 16'd0)      first_err_d = err_addr;
            if (err_cnt_q != 16'hFFFF)   err_cnt_d   = err_cnt_q + 16'd1;
        end

        // Output flops are loaded from the next state so they line up with state_q.
        nxt_addr  = baddr_d + {21'd0, beat_d, 3'd0};
        awvalid_d = (state_d == StWrAddr);
        wvalid_d  = (state_d == StWrData);
        wlast_d   = (state_d == StWrData) && (beat_d == BURST_LEN);
        wdata_d   = (state_d == StWrData) ? {nxt_addr, ~nxt_addr} : 64'd0;
        bready_d  = (state_d == StWrResp);
        arvalid_d = (state_d == StRdAddr);
        rready_d  = (state_d == StRdData);
        addr_d    = (state_d == StWrAddr || state_d == StRdAddr) ? baddr_d : 32'd0;
        busy_d    = (state_d != StIdle) && (state_d != StDone);
        done_d    = (state_d == StDone);
        pass_d    = (state_d == StDone) && (err_cnt_d == 16'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            burst_q     <= '0;
            beat_q      <= '0;
            baddr_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fixed_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            baddr_q     <= baddr_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fixed_en_q  <= 1'b1;
        end
    end

    // Constant burst attributes are gated by a flop so they read as zero while in reset.
    assign io_axi4.awvalid = awvalid_q;
    assign io_axi4.awid    = 4'd0;
    assign io_axi4.awaddr  = addr_q;
    assign io_axi4.awlen   = fixed_en_q ? BURST_LEN : 8'd0;
    assign io_axi4.awsize  = fixed_en_q ? 3'd3 : 3'd0;
    assign io_axi4.awburst = {1'b0, fixed_en_q};
    assign io_axi4.wvalid  = wvalid_q;
    assign io_axi4.wdata   = wdata_q;
    assign io_axi4.wstrb   = {8{fixed_en_q}};
    assign io_axi4.wlast   = wlast_q;
    assign io_axi4.bready  = bready_q;
    assign io_axi4.arvalid = arvalid_q;
    assign io_axi4.arid    = 4'd0;
    assign io_axi4.araddr  = addr_q;
    assign io_axi4.arlen   = fixed_en_q ? BURST_LEN : 8'd0;
    assign io_axi4.arsize  = fixed_en_q ? 3'd3 : 3'd0;
    assign io_axi4.arburst = {1'b0, fixed_en_q};
    assign io_axi4.rready  = rready_q;

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

    logic unused_ids;
    assign unused_ids = ^{io_axi4.bid, io_axi4.rid};

endmodule

// File: tb/tb_axi4_mem_tester.sv
// Randomised bench: an AXI memory model with optional stalls/fault injection, a queue
// scoreboard fed by a reference model, and a monitor that pops on every DUT handshake.
module tb_axi4_mem_tester;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NB    = 2;
    localparam int          BL    = 3;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    logic        busy, done, pass, busy2, done2, pass2;
    logic [15:0] err_cnt, err_cnt2;
    logic [31:0] first_err_addr, first_err_addr2;

    axi4_mem_tester_if a ();
    axi4_mem_tester_if a2 ();

    axi4_mem_tester #(.BASE_ADDR(BASE), .NUM_BURSTS(16'(NB)), .BURST_LEN(8'(BL))) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .io_axi4(a)
    );

    axi4_mem_tester #(.BASE_ADDR(BASE2), .NUM_BURSTS(16'd1), .BURST_LEN(8'd0)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .first_err_addr(first_err_addr2), .io_axi4(a2)
    );

    int n_checks = 0;
    int n_errs   = 0;

    bit          stall_en        = 1'b0;
    int          bresp_err_burst = -1;
    bit          rresp_err       = 1'b0;
    logic [31:0] flip_addr       = 32'hFFFF_FFFF;
    bit          expect_on       = 1'b0;
    int          w_fires         = 0;
    int          bidx            = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [64:0] exp_w[$];
    logic [48:0] exp_res[$];
    logic [31:0] exp2_aw[$];
    logic [64:0] exp2_w[$];
    logic [48:0] exp2_res[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: handshake with no pending expectation", name);
    endtask

    function automatic logic [31:0] baddr(input int k, input int b);
        return BASE + 32'(k * (BL + 1) * 8) + 32'(b * 8);
    endfunction

    // Reference model: expected bus traffic plus the final verdict, derived from the fault set.
    task automatic push_expect();
        logic [31:0] ad, first;
        int errs;
        errs  = 0;
        first = '0;
        bidx  = 0;
        for (int k = 0; k < NB; k++) begin
            exp_aw.push_back(baddr(k, 0));
            for (int b = 0; b <= BL; b++) begin
                ad = baddr(k, b);
                exp_w.push_back({1'(b == BL), ad, ~ad});
            end
            if (k == bresp_err_burst) begin
                if (errs == 0) first = baddr(k, 0);
                errs++;
            end
        end
        for (int k = 0; k < NB; k++) begin
            exp_ar.push_back(baddr(k, 0));
            for (int b = 0; b <= BL; b++) begin
                ad = baddr(k, b);
                if (rresp_err || ad == flip_addr) begin
                    if (errs == 0) first = ad;
                    if (errs < 65535) errs++;
                end
            end
        end
        exp_res.push_back({1'(errs == 0), 16'(errs), first});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_flag(input string name, input bit second);
        bit got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ((second ? done2 : done) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errs++;
            $display("FAIL %s: done still 0 after 4000 cycles, required 1", name);
        end
    endtask

    task automatic run_test(input string name, input bit poke);
        push_expect();
        expect_on = 1'b1;
        pulse_start();
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 chk("busy_when_poked", busy, 1'b1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_flag(name, 1'b0);
        @(negedge clk);
        chk("queues_drained", {exp_aw.size(), exp_w.size(), exp_ar.size(), exp_res.size()}, '0);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {busy, done, pass, err_cnt, first_err_addr, a.awvalid, a.wvalid, a.bready,
                   a.arvalid, a.rready, a.awaddr, a.araddr, a.wdata, a.wlast, a.wstrb, a.awlen,
                   a.awsize, a.awburst, a.arlen, a.arsize, a.arburst}, '0);
    endtask

    // AXI memory model for the main DUT: stalls after each handshake, fault injection on B/R.
    initial begin : slave
        logic [31:0] wq[$], rq[$];
        logic [63:0] mem[logic [31:0]];
        logic [31:0] ad;
        logic [63:0] d;
        int  wbeat, rbeat, bpend, c_aw, c_w, c_ar, c_r;
        bit  f_aw, f_w, f_b, f_ar, f_r, r_aw, r_w, r_ar;
        {a.awready, a.wready, a.arready, a.bvalid, a.rvalid, a.rlast} = '0;
        {a.bid, a.bresp, a.rid, a.rresp, a.rdata} = '0;
        {wbeat, rbeat, bpend, c_aw, c_w, c_ar, c_r} = '0;
        {r_aw, r_w, r_ar} = '0;
        forever begin
            @(negedge clk);
            f_aw = a.awvalid && a.awready;
            f_w  = a.wvalid && a.wready;
            f_b  = a.bvalid && a.bready;
            f_ar = a.arvalid && a.arready;
            f_r  = a.rvalid && a.rready;
            if (!rstn) begin
                wq.delete();
                rq.delete();
                {wbeat, rbeat, bpend, c_aw, c_w, c_ar, c_r} = '0;
                {f_aw, f_w, f_b, f_ar, f_r} = '0;
            end else begin
                if (f_aw) wq.push_back(a.awaddr);
                if (f_w && wq.size() > 0) begin
                    mem[wq[0] + 32'(wbeat * 8)] = a.wdata;
                    if (a.wlast) begin
                        void'(wq.pop_front());
                        wbeat = 0;
                        bpend++;
                    end else wbeat++;
                end
                if (f_ar) rq.push_back(a.araddr);
                if (f_r && rq.size() > 0) begin
                    if (rbeat == BL) begin
                        void'(rq.pop_front());
                        rbeat = 0;
                    end else rbeat++;
                    if (stall_en) c_r = $urandom_range(0, 7);
                end
            end
            @(posedge clk); #1;
            if (!rstn) begin
                {a.awready, a.wready, a.arready, a.bvalid, a.rvalid, a.rlast} = '0;
                {r_aw, r_w, r_ar} = '0;
                continue;
            end
            if (f_aw && stall_en) c_aw = $urandom_range(0, 7);
            if (f_w && stall_en)  c_w  = $urandom_range(0, 7);
            if (f_ar && stall_en) c_ar = $urandom_range(0, 7);
            r_aw = (c_aw == 0); if (c_aw > 0) c_aw--;
            r_w  = (c_w == 0);  if (c_w > 0)  c_w--;
            r_ar = (c_ar == 0); if (c_ar > 0) c_ar--;
            a.awready = r_aw;
            a.wready  = r_w;
            a.arready = r_ar;
            if (f_b) a.bvalid = 1'b0;
            if (!a.bvalid && bpend > 0) begin
                a.bvalid = 1'b1;
                a.bresp  = (bidx == bresp_err_burst) ? 2'b10 : 2'b00;
                bpend--;
                bidx++;
            end
            if (f_r) a.rvalid = 1'b0;
            if (!a.rvalid && rq.size() > 0) begin
                if (c_r > 0) c_r--;
                else begin
                    ad = rq[0] + 32'(rbeat * 8);
                    d  = mem.exists(ad) ? mem[ad] : 64'd0;
                    if (ad == flip_addr) d[0] = ~d[0];
                    a.rdata  = d;
                    a.rresp  = rresp_err ? 2'b10 : 2'b00;
                    a.rlast  = (rbeat == BL);
                    a.rvalid = 1'b1;
                end
            end
        end
    end

    // Monitor for the main DUT: pops the scoreboard on every handshake and on done rising.
    initial begin : monitor
        bit aw_stl, w_stl, ar_stl, done_prev;
        logic [31:0] aw_pa, ar_pa;
        logic [72:0] w_pb;
        {aw_stl, w_stl, ar_stl, done_prev} = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                {aw_stl, w_stl, ar_stl, done_prev} = '0;
                continue;
            end
            if (a.wvalid && a.wready) w_fires++;
            if (expect_on) begin
                if (aw_stl) chk("aw_stable", {a.awvalid, a.awaddr}, {1'b1, aw_pa});
                if (w_stl)  chk("w_stable", {a.wvalid, a.wstrb, a.wlast, a.wdata}, {1'b1, w_pb});
                if (ar_stl) chk("ar_stable", {a.arvalid, a.araddr}, {1'b1, ar_pa});
                if (a.awvalid && a.awready) begin
                    if (exp_aw.size() == 0) miss("aw_extra");
                    else chk("aw_beat", {a.awid, a.awlen, a.awsize, a.awburst, a.awaddr},
                             {4'd0, 8'(BL), 3'd3, 2'b01, exp_aw.pop_front()});
                end
                if (a.wvalid && a.wready) begin
                    if (exp_w.size() == 0) miss("w_extra");
                    else chk("w_beat", {a.wstrb, a.wlast, a.wdata}, {8'hFF, exp_w.pop_front()});
                end
                if (a.arvalid && a.arready) begin
                    if (exp_ar.size() == 0) miss("ar_extra");
                    else chk("ar_beat", {a.arid, a.arlen, a.arsize, a.arburst, a.araddr},
                             {4'd0, 8'(BL), 3'd3, 2'b01, exp_ar.pop_front()});
                end
                if (done && !done_prev) begin
                    if (exp_res.size() == 0) miss("done_extra");
                    else chk("result", {busy, pass, err_cnt, first_err_addr},
                             {1'b0, exp_res.pop_front()});
                end
            end
            aw_stl    = a.awvalid && !a.awready;
            w_stl     = a.wvalid && !a.wready;
            ar_stl    = a.arvalid && !a.arready;
            aw_pa     = a.awaddr;
            ar_pa     = a.araddr;
            w_pb      = {a.wstrb, a.wlast, a.wdata};
            done_prev = done;
        end
    end

    // Always-ready single-beat memory for the second DUT.
    initial begin : slave2
        logic [63:0] mem2;
        bit f_w, f_b, f_ar, f_r;
        mem2 = '0;
        {a2.bvalid, a2.rvalid, a2.rlast, a2.bid, a2.bresp, a2.rid, a2.rresp, a2.rdata} = '0;
        {a2.awready, a2.wready, a2.arready} = 3'b111;
        forever begin
            @(negedge clk);
            f_w  = rstn && a2.wvalid && a2.wready;
            f_b  = rstn && a2.bvalid && a2.bready;
            f_ar = rstn && a2.arvalid && a2.arready;
            f_r  = rstn && a2.rvalid && a2.rready;
            if (f_w) mem2 = a2.wdata;
            @(posedge clk); #1;
            if (f_b) a2.bvalid = 1'b0;
            if (f_w) a2.bvalid = 1'b1;
            if (f_r) a2.rvalid = 1'b0;
            if (f_ar) begin
                a2.rdata  = mem2;
                a2.rlast  = 1'b1;
                a2.rvalid = 1'b1;
            end
        end
    end

    initial begin : monitor2
        bit done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (a2.awvalid && a2.awready) begin
                    if (exp2_aw.size() == 0) miss("aw2_extra");
                    else chk("aw2_beat", {a2.awlen, a2.awaddr}, {8'd0, exp2_aw.pop_front()});
                end
                if (a2.wvalid && a2.wready) begin
                    if (exp2_w.size() == 0) miss("w2_extra");
                    else chk("w2_beat", {a2.wstrb, a2.wlast, a2.wdata},
                             {8'hFF, exp2_w.pop_front()});
                end
                if (done2 && !done_prev) begin
                    if (exp2_res.size() == 0) miss("done2_extra");
                    else chk("result2", {pass2, err_cnt2, first_err_addr2}, exp2_res.pop_front());
                end
            end
            done_prev = rstn && done2;
        end
    end

    initial begin : stimulus
        int r;
        #2 rstn = 1'b0;
        #3 check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", {a.awvalid, a.wvalid, a.arvalid, a.bready, a.rready, busy, done},
            '0);

        run_test("ideal", 1'b0);
        flip_addr = 32'h0000_1028;
        run_test("bit_flip", 1'b0);
        flip_addr       = 32'hFFFF_FFFF;
        bresp_err_burst = 1;
        rresp_err       = 1'b1;
        run_test("resp_errors", 1'b0);
        bresp_err_burst = -1;
        rresp_err       = 1'b0;
        stall_en        = 1'b1;
        run_test("stalled_with_poke", 1'b1);

        // Abandon a run mid-burst; no expectations are queued for it.
        stall_en  = 1'b0;
        expect_on = 1'b0;
        w_fires   = 0;
        bidx      = 0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (w_fires >= 1) break;
        end
        chk("reached_second_beat", {a.wvalid, w_fires}, {1'b1, 32'd1});
        rstn = 1'b0;
        #1 check_all_zero("midburst_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_valid_until_start", {a.awvalid, a.wvalid, a.arvalid, busy}, '0);
        stall_en = 1'b1;
        run_test("after_reset", 1'b0);

        for (int it = 0; it < 4; it++) begin
            stall_en        = 1'($urandom_range(0, 1));
            r               = $urandom_range(0, NB);
            bresp_err_burst = (r == NB) ? -1 : r;
            rresp_err       = ($urandom_range(0, 3) == 0);
            flip_addr       = $urandom_range(0, 1) ?
                              baddr($urandom_range(0, NB - 1), $urandom_range(0, BL)) :
                              32'hFFFF_FFFF;
            run_test("random", 1'b0);
        end

        exp2_aw.push_back(BASE2);
        exp2_w.push_back({1'b1, BASE2, ~BASE2});
        exp2_res.push_back({1'b1, 16'd0, 32'd0});
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        wait_flag("single_beat", 1'b1);
        @(negedge clk);
        chk("queues2_drained", {exp2_aw.size(), exp2_w.size(), exp2_res.size()}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
